// File: rtl/sysid_ext.sv
// Extended system-ID slave: RO identity words, uptime counter with atomic
// high-word snapshot, byte-writable scratch, control, pipelined read path.
module sysid_ext #(
    parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd1395340222,
    parameter int          CNT_W         = 64,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] A_ID  = 3'd0;
    localparam logic [2:0] A_TS  = 3'd1;
    localparam logic [2:0] A_LO  = 3'd2;
    localparam logic [2:0] A_HI  = 3'd3;
    localparam logic [2:0] A_SCR = 3'd4;
    localparam logic [2:0] A_CTL = 3'd5;

    logic             wr_en;
    logic             rd_en;
    logic             clear;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      shadow_q;
    logic [31:0]      shadow_d;
    logic [31:0]      scratch_q;
    logic [31:0]      scratch_d;
    logic             freeze_q;
    logic             freeze_d;
    logic [63:0]      cnt_ext;
    logic [31:0]      rd_mux;
    logic             vld_q [READ_LATENCY];
    logic [31:0]      dat_q [READ_LATENCY];

    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read & ~write;
    assign cnt_ext = 64'(cnt_q);

    always_comb begin
        rd_mux = '0;
        unique case (address)
            A_ID:    rd_mux = ID_VALUE;
            A_TS:    rd_mux = TIMESTAMP;
            A_LO:    rd_mux = cnt_ext[31:0];
            A_HI:    rd_mux = shadow_q;
            A_SCR:   rd_mux = scratch_q;
            A_CTL:   rd_mux = {31'd0, freeze_q};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        shadow_d  = shadow_q;
        clear     = 1'b0;
        if (wr_en && address == A_SCR) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch_d[8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end
        if (wr_en && address == A_CTL && byteenable[0]) begin
            freeze_d = writedata[0];
            clear    = writedata[1];
        end
        // LO read latches the matching high bits so HI is never torn
        if (rd_en && address == A_LO) begin
            shadow_d = cnt_ext[63:32];
        end
        if (clear) begin
            cnt_d = '0;
        end else if (freeze_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            scratch_q <= SCRATCH_RESET;
            freeze_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            freeze_q  <= freeze_d;
        end
    end

    // Data stages carry zero when empty so readdata is 0 without valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            dat_q[0] <= rd_en ? rd_mux : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_ext.sv
// Bench for sysid_ext: two builds (64-bit/latency 1, 33-bit/latency 3)
// compared against a register-map level reference model.
module tb_sysid_ext;

    localparam logic [31:0] ID_A = 32'hC0DE_0001;
    localparam logic [31:0] ID_B = 32'hBEEF_0003;
    localparam logic [31:0] TS   = 32'd1395340222;
    localparam logic [31:0] SR_A = 32'h1234_5678;
    localparam logic [31:0] SR_B = 32'h0BAD_F00D;
    localparam int          NS   = 4096;

    logic        clk;
    logic        rst_n [2];
    logic        in_cs [2];
    logic        in_rd [2];
    logic        in_wr [2];
    logic [2:0]  in_ad [2];
    logic [31:0] in_wd [2];
    logic [3:0]  in_be [2];
    logic [31:0] o_d   [2];
    logic        o_v   [2];

    int errs;
    int checks;
    int cyc;

    logic [63:0] m_cnt [2];
    logic [63:0] m_sh  [2];
    logic [31:0] m_scr [2];
    bit          m_frz [2];
    bit          sch_v [2][NS];
    logic [31:0] sch_d [2][NS];
    bit          exp_v [2];
    logic [31:0] exp_d [2];

    sysid_ext #(
        .ID_VALUE(ID_A), .TIMESTAMP(TS), .CNT_W(64),
        .READ_LATENCY(1), .SCRATCH_RESET(SR_A)
    ) u_a (
        .clock(clk), .reset_n(rst_n[0]), .address(in_ad[0]),
        .chipselect(in_cs[0]), .read(in_rd[0]), .write(in_wr[0]),
        .writedata(in_wd[0]), .byteenable(in_be[0]),
        .readdata(o_d[0]), .readdatavalid(o_v[0])
    );

    sysid_ext #(
        .ID_VALUE(ID_B), .TIMESTAMP(TS), .CNT_W(33),
        .READ_LATENCY(3), .SCRATCH_RESET(SR_B)
    ) u_b (
        .clock(clk), .reset_n(rst_n[1]), .address(in_ad[1]),
        .chipselect(in_cs[1]), .read(in_rd[1]), .write(in_wr[1]),
        .writedata(in_wd[1]), .byteenable(in_be[1]),
        .readdata(o_d[1]), .readdatavalid(o_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] cmask(int i);
        return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << 33) - 64'd1);
    endfunction

    task automatic model_reset(int i);
        m_cnt[i] = '0;
        m_sh[i]  = '0;
        m_scr[i] = (i == 0) ? SR_A : SR_B;
        m_frz[i] = 1'b0;
        for (int k = cyc + 1; k < NS; k++) begin
            sch_v[i][k] = 1'b0;
            sch_d[i][k] = '0;
        end
    endtask

    // One rising edge of the register map, from the current bus inputs
    task automatic model_edge(int i);
        bit          wa;
        bit          ra;
        bit          clr;
        bit          ofrz;
        logic [31:0] v;
        wa   = in_cs[i] && in_wr[i];
        ra   = in_cs[i] && in_rd[i] && !in_wr[i];
        clr  = 1'b0;
        ofrz = m_frz[i];
        if (ra) begin
            case (in_ad[i])
                3'd0:    v = (i == 0) ? ID_A : ID_B;
                3'd1:    v = TS;
                3'd2:    v = m_cnt[i][31:0];
                3'd3:    v = m_sh[i][31:0];
                3'd4:    v = m_scr[i];
                3'd5:    v = {31'd0, m_frz[i]};
                default: v = '0;
            endcase
            sch_v[i][cyc + lat(i)] = 1'b1;
            sch_d[i][cyc + lat(i)] = v;
            if (in_ad[i] == 3'd2) m_sh[i] = m_cnt[i] >> 32;
        end
        if (wa && in_ad[i] == 3'd4) begin
            for (int b = 0; b < 4; b++)
                if (in_be[i][b]) m_scr[i][8*b +: 8] = in_wd[i][8*b +: 8];
        end
        if (wa && in_ad[i] == 3'd5 && in_be[i][0]) begin
            m_frz[i] = in_wd[i][0];
            clr      = in_wd[i][1];
        end
        if (clr) m_cnt[i] = '0;
        else if (!ofrz) m_cnt[i] = (m_cnt[i] + 64'd1) & cmask(i);
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++)
            if (rst_n[i]) model_edge(i);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = sch_v[i][cyc];
            exp_d[i] = sch_v[i][cyc] ? sch_d[i][cyc] : 32'd0;
        end
    endtask

    task automatic drv(int i, logic cs, logic rd, logic wr,
                       logic [2:0] ad, logic [31:0] wd, logic [3:0] be);
        in_cs[i] = cs;
        in_rd[i] = rd;
        in_wr[i] = wr;
        in_ad[i] = ad;
        in_wd[i] = wd;
        in_be[i] = be;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 3'd0, 32'd0, 4'd0);
        drv(1, 0, 0, 0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic test_reset();
        idle();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        model_reset(0);
        model_reset(1);
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_v[i] !== 1'b0 || o_d[i] !== 32'd0) begin
                errs++;
                $display("FAIL reset_out[%0d]: v=%b d=%h want v=0 d=0",
                         i, o_v[i], o_d[i]);
            end
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        drv(0, 1, 1, 0, 3'd4, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== SR_A) begin
            errs++;
            $display("FAIL reset_scratch: v=%b d=%h want %h",
                     o_v[0], o_d[0], SR_A);
        end
        drv(0, 1, 1, 0, 3'd2, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'd1) begin
            errs++;
            $display("FAIL reset_uptime: v=%b d=%h want 1", o_v[0], o_d[0]);
        end
    endtask

    task automatic test_id_reads();
        logic [2:0]  ad;
        logic [31:0] want;
        for (int k = 0; k < 3; k++) begin
            ad   = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd6;
            want = (k == 0) ? ID_A : (k == 1) ? TS : 32'd0;
            drv(0, 1, 1, 0, ad, 32'd0, 4'd0);
            step();
            checks++;
            if (o_v[0] !== 1'b1 || o_d[0] !== want || exp_d[0] !== want) begin
                errs++;
                $display("FAIL id_read[%0d]: v=%b d=%h want %h",
                         ad, o_v[0], o_d[0], want);
            end
        end
        idle();
        step();
        checks++;
        if (o_v[0] !== 1'b0 || o_d[0] !== 32'd0) begin
            errs++;
            $display("FAIL id_tail: v=%b d=%h want v=0 d=0", o_v[0], o_d[0]);
        end
    endtask

    task automatic test_scratch();
        drv(0, 1, 0, 1, 3'd4, 32'hAABB_CCDD, 4'b1111);
        step();
        drv(0, 1, 0, 1, 3'd4, 32'h1122_3344, 4'b0101);
        step();
        drv(0, 1, 1, 0, 3'd4, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'hAA22_CC44) begin
            errs++;
            $display("FAIL scratch_be: v=%b d=%h want aa22cc44",
                     o_v[0], o_d[0]);
        end
        drv(0, 1, 0, 1, 3'd0, 32'hFFFF_FFFF, 4'b1111);
        step();
        drv(0, 1, 1, 0, 3'd0, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== ID_A) begin
            errs++;
            $display("FAIL id_ro: v=%b d=%h want %h", o_v[0], o_d[0], ID_A);
        end
        idle();
        step();
    endtask

    task automatic test_freeze();
        logic [31:0] v1;
        drv(0, 1, 0, 1, 3'd5, 32'd1, 4'b0001);
        step();
        drv(0, 1, 1, 0, 3'd2, 32'd0, 4'd0);
        step();
        v1 = o_d[0];
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== exp_d[0]) begin
            errs++;
            $display("FAIL frz_lo1: v=%b d=%h want %h",
                     o_v[0], o_d[0], exp_d[0]);
        end
        idle();
        repeat (10) step();
        drv(0, 1, 1, 0, 3'd2, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== v1) begin
            errs++;
            $display("FAIL frz_hold: d=%h want %h", o_d[0], v1);
        end
        drv(0, 1, 0, 1, 3'd5, 32'd3, 4'b0001);
        step();
        drv(0, 1, 1, 0, 3'd2, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'd0) begin
            errs++;
            $display("FAIL frz_clear: d=%h want 0", o_d[0]);
        end
        drv(0, 1, 1, 0, 3'd5, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'd1) begin
            errs++;
            $display("FAIL ctl_read: d=%h want 1", o_d[0]);
        end
        drv(0, 1, 0, 1, 3'd5, 32'd0, 4'b0001);
        step();
        idle();
        repeat (5) step();
        drv(0, 1, 1, 0, 3'd2, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'd5 || exp_d[0] !== 32'd5) begin
            errs++;
            $display("FAIL frz_resume: d=%h want 5", o_d[0]);
        end
        idle();
        step();
    endtask

    task automatic test_cs_rw();
        drv(0, 0, 1, 0, 3'd4, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b0) begin
            errs++;
            $display("FAIL cs_low_read: v=%b want 0", o_v[0]);
        end
        drv(0, 1, 1, 1, 3'd4, 32'hDEAD_BEEF, 4'b1111);
        step();
        checks++;
        if (o_v[0] !== 1'b0 || o_d[0] !== 32'd0) begin
            errs++;
            $display("FAIL rw_novalid: v=%b d=%h want 0", o_v[0], o_d[0]);
        end
        drv(0, 0, 0, 1, 3'd4, 32'h0, 4'b1111);
        step();
        drv(0, 1, 1, 0, 3'd4, 32'd0, 4'd0);
        step();
        checks++;
        if (o_v[0] !== 1'b1 || o_d[0] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL rw_landed: v=%b d=%h want deadbeef",
                     o_v[0], o_d[0]);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int k = 0; k < 60; k++) begin
            r = $urandom;
            drv(0, r[0] | r[1], r[2], r[3] & r[4], r[7:5],
                $urandom, r[11:8]);
            step();
            checks++;
            if (o_v[0] !== exp_v[0] || o_d[0] !== exp_d[0]) begin
                errs++;
                $display("FAIL rand[%0d]: v=%b d=%h want v=%b d=%h",
                         k, o_v[0], o_d[0], exp_v[0], exp_d[0]);
            end
        end
        idle();
        step();
        checks++;
        if (o_v[0] !== exp_v[0] || o_d[0] !== exp_d[0]) begin
            errs++;
            $display("FAIL rand_tail: v=%b d=%h want v=%b d=%h",
                     o_v[0], o_d[0], exp_v[0], exp_d[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ad;
        logic [31:0] want;
        for (int k = 0; k < 4; k++) begin
            ad = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd4 : 3'd6;
            drv(1, 1, 1, 0, ad, 32'd0, 4'd0);
            step();
            want = (k == 2) ? ID_B : (k == 3) ? TS : 32'd0;
            checks++;
            if (o_v[1] !== (k >= 2) || o_d[1] !== want) begin
                errs++;
                $display("FAIL b2b[%0d]: v=%b d=%h want v=%0d d=%h",
                         k, o_v[1], o_d[1], k >= 2, want);
            end
        end
        idle();
        rst_n[1] = 1'b0;
        model_reset(1);
        #1;
        checks++;
        if (o_v[1] !== 1'b0 || o_d[1] !== 32'd0) begin
            errs++;
            $display("FAIL async_rst: v=%b d=%h want 0", o_v[1], o_d[1]);
        end
        step();
        rst_n[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (o_v[1] !== 1'b0 || o_d[1] !== 32'd0) begin
                errs++;
                $display("FAIL rst_drop[%0d]: v=%b d=%h want 0",
                         k, o_v[1], o_d[1]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] got [$];
        logic [31:0] lo;
        logic [31:0] hi;
        force u_b.cnt_q = 33'h0_FFFF_FFFC;
        #1;
        release u_b.cnt_q;
        m_cnt[1] = 64'h0_FFFF_FFFC;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) drv(1, 1, 1, 0, k[0] ? 3'd3 : 3'd2, 32'd0, 4'd0);
            else idle();
            step();
            checks++;
            if (o_v[1] !== exp_v[1] || o_d[1] !== exp_d[1]) begin
                errs++;
                $display("FAIL snap[%0d]: v=%b d=%h want v=%b d=%h",
                         k, o_v[1], o_d[1], exp_v[1], exp_d[1]);
            end
            if (o_v[1] === 1'b1) got.push_back(o_d[1]);
        end
        checks++;
        if (got.size() != 8) begin
            errs++;
            $display("FAIL snap_count: got %0d want 8", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                lo = got[2*j];
                hi = got[2*j+1];
                checks++;
                if (hi !== ((lo >= 32'hF000_0000) ? 32'd0 : 32'd1)) begin
                    errs++;
                    $display("FAIL snap_pair[%0d]: lo=%h hi=%h", j, lo, hi);
                end
            end
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        cyc    = 0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NS; k++) begin
                sch_v[i][k] = 1'b0;
                sch_d[i][k] = '0;
            end
        test_reset();
        test_id_reads();
        test_scratch();
        test_freeze();
        test_cs_rw();
        test_random();
        test_back_to_back();
        test_snapshot();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
